// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, redirect input and the decode-facing valid/ready output.
// The master side belongs to the fetch unit and the slave side belongs to its environment.
interface fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, reads the combinational instruction ROM and queues
// {pc, instr} pairs in a small FIFO for decode. Execute can redirect the PC.
//
// state   | meaning
// ST_RUN  | fetching; a word is pushed whenever the FIFO has room
// ST_HALT | PC misaligned or beyond the ROM; only a redirect or rst leaves this state
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          ROM_WORDS = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam int              PW        = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [32:0]     ROM_BYTES = 33'(ROM_WORDS) * 33'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];

  logic          fifo_valid;
  logic          pop;
  logic          push;
  logic          pc_ok;

  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < ROM_BYTES);
  endfunction

  always_comb begin
    fifo_valid = (count_q != '0);
    pop        = fifo_valid & bus.out_ready;
    pc_ok      = addr_ok(pc_q);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = (state_q == ST_RUN) && !bus.redirect_valid && pc_ok &&
                 ((count_q != DEPTH_C) || pop);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (bus.redirect_valid) begin
      // Flush wins over a simultaneous pop; decode already took that head.
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = addr_ok(bus.redirect_pc) ? ST_RUN : ST_HALT;
    end else begin
      if ((state_q == ST_RUN) && !pc_ok) begin
        state_d = ST_HALT;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= bus.rom_data;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_pc    = fifo_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;
  assign bus.out_instr = fifo_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign bus.halted    = (state_q == ST_HALT);

endmodule
